conv_deinterleave: RTL and testbench

// Receive-side convolutional deinterleaver (I=12, M=17, DVB-style), directly downstream of the byte interleaver.
// - Acquires packet sync from 0x47/0xB8 bytes spaced PKT_LEN apart in the interleaved stream.
// - Aligns its branch commutator so that sync bytes land on branch 0.
// - Branch j (0..I-1) delays by (I-1-j)*M branch visits; interleaver + deinterleaver = I*(I-1)*M bytes end-to-end.

---
 rtl/conv_deinterleave_pkg.sv | 45 ++++
 rtl/conv_deinterleave_ram.sv | 28 ++
 rtl/conv_deinterleave.sv | 202 ++++++++++++++++++++
 tb/tb_conv_deinterleave.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_deinterleave_pkg.sv
// Shared DVB constants for the convolutional interleaver pair, plus the derived widths and branch FIFO layout.
package conv_deinterleave_pkg;

  localparam int I         = 12;
  localparam int M         = 17;
  localparam int PKT_LEN   = I * M;
  localparam logic [7:0] SYNC_BYTE = 8'h47;
  localparam logic [7:0] SYNC_INV  = 8'hB8;
  localparam int N_CONFIRM = 3;
  localparam int N_MISS    = 3;

  localparam int FILL_MAX  = I * (I - 1) * M;
  localparam int RAM_DEPTH = M * I * (I - 1) / 2;

  localparam int POS_W  = $clog2(PKT_LEN);
  localparam int BR_W   = $clog2(I);
  localparam int PTR_W  = $clog2((I - 1) * M);
  localparam int ADDR_W = $clog2(RAM_DEPTH);
  localparam int FILL_W = $clog2(FILL_MAX + 1);
  localparam int HIT_W  = $clog2(N_CONFIRM + 1);
  localparam int MISS_W = $clog2(N_MISS + 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } state_t;

  function automatic int branch_len(input int j);
    return (I - 1 - j) * M;
  endfunction

  // Branches are packed back to back, longest (branch 0) first.
  function automatic int branch_base(input int j);
    int acc;
    acc = 0;
    for (int b = 0; b < j; b++) acc += (I - 1 - b) * M;
    return acc;
  endfunction

  function automatic logic is_sync(input logic [7:0] b);
    return (b == SYNC_BYTE) || (b == SYNC_INV);
  endfunction

endpackage

// File: rtl/conv_deinterleave_ram.sv
// Simple dual-port byte RAM holding all branch FIFOs; read-first, one-cycle registered read, no reset.
module conv_deinterleave_ram
  import conv_deinterleave_pkg::*;
#(
  parameter int DEPTH = RAM_DEPTH,
  parameter int AW    = ADDR_W
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdat,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdat
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_q;

  // Non-blocking write means a same-address read returns the old byte.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdat;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdat = r_q;

endmodule

// File: rtl/conv_deinterleave.sv
// DVB convolutional deinterleaver with 0x47/0xB8 packet sync acquisition and branch alignment.
// Outputs registered one clock after each din_valid byte; din_valid low freezes all state.
module conv_deinterleave
  import conv_deinterleave_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       syn_out,
  output logic       lock,
  output logic       sync_err
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [POS_W-1:0]    r_pos;
  logic [BR_W-1:0]     r_branch;
  logic [PTR_W-1:0]    r_ptr [I-1];
  logic [FILL_W-1:0]   r_fill;
  logic [HIT_W-1:0]    r_hits;
  logic [MISS_W-1:0]   r_miss;

  logic                r_vld;
  logic                r_syn;
  logic                r_sel_ram;
  logic [7:0]          r_dbyp;
  logic                r_sync_err;

  logic                w_match;
  logic                w_at_sync;
  logic [POS_W-1:0]    w_pos_nxt;
  logic [BR_W-1:0]     w_br_nxt;
  logic                w_confirm;
  logic                w_proc;
  logic                w_is_ram;
  logic                w_clear;
  logic                w_err;
  logic                w_full;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic                w_ram_en;
  logic [7:0]          w_ram_q;
  logic [ADDR_W-1:0]   w_base [I-1];
  logic [PTR_W-1:0]    w_last [I-1];

  for (genvar g = 0; g < I - 1; g++) begin : g_branch_const
    assign w_base[g] = ADDR_W'(branch_base(g));
    assign w_last[g] = PTR_W'(branch_len(g) - 1);
  end

  assign w_match   = is_sync(din);
  assign w_at_sync = (r_pos == '0);
  assign w_pos_nxt = (r_pos == POS_W'(PKT_LEN - 1)) ? '0 : r_pos + 1'b1;
  assign w_br_nxt  = (r_branch == BR_W'(I - 1)) ? '0 : r_branch + 1'b1;
  assign w_is_ram  = (r_branch != BR_W'(I - 1));
  assign w_full    = (r_fill == FILL_W'(FILL_MAX));

  // The confirming sync byte is the first deinterleaved byte (k=0).
  assign w_confirm = (r_state == ST_VERIFY) && w_at_sync && w_match &&
                     (r_hits == HIT_W'(N_CONFIRM - 1));
  assign w_proc    = din_valid && ((r_state == ST_LOCK) || w_confirm);
  assign w_ram_en  = w_proc && w_is_ram;

  always_comb begin
    w_ram_addr = '0;
    for (int j = 0; j < I - 1; j++) begin
      if (r_branch == BR_W'(j)) w_ram_addr = w_base[j] + ADDR_W'(r_ptr[j]);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_err       = 1'b0;
    if (din_valid) begin
      case (r_state)
        ST_SEARCH: begin
          if (w_match) w_state_nxt = ST_VERIFY;
        end
        ST_VERIFY: begin
          if (w_at_sync) begin
            if (!w_match) begin
              w_state_nxt = ST_SEARCH;
              w_clear     = 1'b1;
            end else if (r_hits == HIT_W'(N_CONFIRM - 1)) begin
              w_state_nxt = ST_LOCK;
            end
          end
        end
        ST_LOCK: begin
          if (w_at_sync && !w_match) begin
            w_err = 1'b1;
            if (r_miss == MISS_W'(N_MISS - 1)) begin
              w_state_nxt = ST_SEARCH;
              w_clear     = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = ST_SEARCH;
          w_clear     = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_SEARCH;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos    <= '0;
      r_branch <= '0;
      r_hits   <= '0;
      r_miss   <= '0;
      r_fill   <= '0;
    end else if (din_valid) begin
      if (w_clear) begin
        r_pos    <= '0;
        r_branch <= '0;
        r_hits   <= '0;
        r_miss   <= '0;
        r_fill   <= '0;
      end else begin
        case (r_state)
          ST_SEARCH: begin
            if (w_match) begin
              r_pos    <= POS_W'(1);
              r_branch <= BR_W'(1);
              r_hits   <= HIT_W'(1);
            end
          end
          ST_VERIFY: begin
            r_pos    <= w_pos_nxt;
            r_branch <= w_br_nxt;
            r_miss   <= '0;
            if (w_at_sync) r_hits <= r_hits + 1'b1;
          end
          ST_LOCK: begin
            r_pos    <= w_pos_nxt;
            r_branch <= w_br_nxt;
            if (w_at_sync) r_miss <= w_match ? '0 : r_miss + 1'b1;
          end
          default: ;
        endcase
        if (w_proc && !w_full) r_fill <= r_fill + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < I - 1; j++) r_ptr[j] <= '0;
    end else if (din_valid) begin
      for (int j = 0; j < I - 1; j++) begin
        if (w_clear) r_ptr[j] <= '0;
        else if (w_proc && (r_branch == BR_W'(j)))
          r_ptr[j] <= (r_ptr[j] == w_last[j]) ? '0 : r_ptr[j] + 1'b1;
      end
    end
  end

  conv_deinterleave_ram u_deint_ram (
    .clk     (clk),
    .i_we    (w_ram_en),
    .i_waddr (w_ram_addr),
    .i_wdat  (din),
    .i_re    (w_ram_en),
    .i_raddr (w_ram_addr),
    .o_rdat  (w_ram_q)
  );

  // RAM data already sits in a register; only the branch select is staged here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld      <= 1'b0;
      r_syn      <= 1'b0;
      r_sel_ram  <= 1'b0;
      r_dbyp     <= '0;
      r_sync_err <= 1'b0;
    end else begin
      r_vld      <= w_proc && w_full;
      r_syn      <= w_proc && w_full && w_at_sync;
      r_sync_err <= w_err;
      if (w_proc) begin
        r_sel_ram <= w_is_ram;
        if (!w_is_ram) r_dbyp <= din;
      end
    end
  end

  assign dout       = r_vld ? (r_sel_ram ? w_ram_q : r_dbyp) : 8'h00;
  assign dout_valid = r_vld;
  assign syn_out    = r_syn;
  assign sync_err   = r_sync_err;
  assign lock       = (r_state == ST_LOCK);

endmodule

// File: tb/tb_conv_deinterleave.sv
// Bench: a reference interleaver feeds the deinterleaver; a scoreboard checks that the recovered bytes equal the source.
module tb_conv_deinterleave;

  localparam int PKT  = 204;
  localparam int BR   = 12;
  localparam int LAT  = 2244;
  localparam int BIG  = 1 << 30;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic [7:0] dout;
  logic       dout_valid;
  logic       syn_out;
  logic       lock;
  logic       sync_err;

  typedef struct packed {
    logic [7:0] b;
    logic       syn;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   corrupt_en;
  int   ep0_lo, ep0_hi, ep1_lo;
  bit   chk_pend;
  int   chk_s;

  conv_deinterleave dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .syn_out    (syn_out),
    .lock       (lock),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source packets: sync byte then a payload whose bits 7 and 6 are equal, so no payload byte looks like a sync.
  function automatic logic [7:0] src(input int i);
    int p;
    int b;
    logic [6:0] v;
    p = i / PKT;
    b = i % PKT;
    v = 7'((p * 13 + b) % 128);
    if (b == 0) return (p % 8 == 7) ? 8'hB8 : 8'h47;
    return {v[6], v};
  endfunction

  function automatic bit is_corrupt(input int i);
    return corrupt_en && (i == 3264 || i == 3468 || i == 4080 || i == 4284 || i == 4488);
  endfunction

  function automatic logic [7:0] src_eff(input int i);
    return is_corrupt(i) ? 8'h00 : src(i);
  endfunction

  // Reference interleaver, zero-initialised: branch j delays by j*PKT stream bytes.
  function automatic logic [7:0] stream(input int s);
    int j;
    int idx;
    j   = s % BR;
    idx = s - j * PKT;
    return (idx >= 0) ? src_eff(idx) : 8'h00;
  endfunction

  function automatic bit locked_after(input int s);
    return (s >= ep0_lo && s < ep0_hi) || (s >= ep1_lo);
  endfunction

  function automatic bit processed(input int s);
    return (s >= ep0_lo && s <= ep0_hi) || (s >= ep1_lo);
  endfunction

  function automatic int ep_start(input int s);
    return (s >= ep1_lo) ? ep1_lo : ep0_lo;
  endfunction

  task automatic step(input bit v, input logic [7:0] b, input int s);
    exp_t e;
    @(negedge clk);
    if (chk_pend) begin
      chk("lock", 32'(lock), 32'(locked_after(chk_s)));
      chk("sync_err", 32'(sync_err), 32'(is_corrupt(chk_s)));
      chk_pend = 1'b0;
    end
    din       = b;
    din_valid = v;
    if (v) begin
      if (processed(s) && (s - ep_start(s) >= LAT)) begin
        e.b   = src_eff(s - LAT);
        e.syn = ((s - LAT) % PKT == 0);
        q.push_back(e);
      end
      chk_pend = 1'b1;
      chk_s    = s;
    end
  endtask

  task automatic feed(input int n, input bit gaps);
    int g;
    for (int s = 0; s < n; s++) begin
      g = 0;
      while (gaps && g < 8 && $urandom_range(1, 0) == 1) begin
        step(1'b0, 8'h47, 0);
        g++;
      end
      step(1'b1, stream(s), s);
    end
    step(1'b0, 8'h00, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic sync_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    din_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (dout_valid === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got dout=%0h, want no output at %0t", dout, $time);
      end else begin
        e = q.pop_front();
        chk("dout", 32'(dout), 32'(e.b));
        chk("syn_out", 32'(syn_out), 32'(e.syn));
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    din        = 8'h00;
    din_valid  = 1'b0;
    chk_pend   = 1'b0;
    corrupt_en = 1'b0;
    ep0_lo     = BIG;
    ep0_hi     = BIG;
    ep1_lo     = BIG;
    chk_s      = 0;

    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_dout_valid", 32'(dout_valid), 32'h0);
    chk("rst_syn_out", 32'(syn_out), 32'h0);
    chk("rst_lock", 32'(lock), 32'h0);
    chk("rst_sync_err", 32'(sync_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle zeros: never locks.
    for (int i = 0; i < 300; i++) step(1'b1, 8'h00, -1);

    // Lock at 408; two misses tolerated; third miss at 4488 drops lock; reacquire at 5100.
    corrupt_en = 1'b1;
    ep0_lo     = 408;
    ep0_hi     = 4488;
    ep1_lo     = 5100;
    feed(40 * PKT, 1'b0);
    chk("drain_a", 32'(q.size()), 32'h0);

    corrupt_en = 1'b0;
    sync_reset();
    ep0_lo = 408;
    ep0_hi = BIG;
    ep1_lo = BIG;
    for (int s = 0; s < 3500; s++) begin
      while ($urandom_range(1, 0) == 1) step(1'b0, 8'h47, 0);
      step(1'b1, stream(s), s);
    end
    step(1'b0, 8'h00, 0);
    #1;
    chk("pre_rst_valid", 32'(dout_valid), 32'h1);
    chk("pre_rst_lock", 32'(lock), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_dout", 32'(dout), 32'h0);
    chk("arst_dout_valid", 32'(dout_valid), 32'h0);
    chk("arst_syn_out", 32'(syn_out), 32'h0);
    chk("arst_lock", 32'(lock), 32'h0);
    chk("arst_sync_err", 32'(sync_err), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("drain_b", 32'(q.size()), 32'h0);

    feed(3000, 1'b0);
    chk("drain_c", 32'(q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
